// File: rtl/fetch_unit_pkg.sv
// Shared instruction-set definitions for the fetch stage, ROM and ALU: opcodes,
// operand field positions and the bubble (NOP) word.
package fetch_unit_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_STO  = 4'h1,
        OP_IMUL = 4'h2,
        OP_LED  = 4'h3,
        OP_ADD  = 4'h4,
        OP_SUB  = 4'h5,
        OP_JMP  = 4'h6,
        OP_BLE  = 4'h7
    } opcode_e;

    localparam int OP_MSB   = 27;
    localparam int OP_LSB   = 24;
    localparam int DST_MSB  = 23;
    localparam int DST_LSB  = 16;
    localparam int SRC1_MSB = 15;
    localparam int SRC1_LSB = 8;
    localparam int SRC0_MSB = 7;
    localparam int SRC0_LSB = 0;

    localparam logic [27:0] NOP_INSTR = {OP_NOP, 24'd0};

    // Pack an opcode and its 24-bit operand into a full instruction word.
    function automatic logic [27:0] make_instr(input opcode_e op, input logic [23:0] operand);
        return {op, operand};
    endfunction

endpackage

// File: rtl/fetch_unit_program_counter.sv
// Program counter: reset > load > advance > hold, wrapping naturally at 2^ADDR_W.
module program_counter
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] RESET_ADDR = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              advance_en,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_value,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_q;

    // Next-PC selection; a load (branch) beats an advance.
    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            pc_d = load_value;
        end else if (advance_en) begin
            pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            pc_d = pc_q;
        end
    end

    // PC register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_ADDR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, instruction register and valid flag.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                 ADDR_W     = 16,
    parameter int                 INSTR_W    = 28,
    parameter logic [ADDR_W-1:0]  RESET_ADDR = {ADDR_W{1'b0}},
    parameter logic [INSTR_W-1:0] NOP_WORD   = NOP_INSTR
) (
    input  logic               Clock,
    input  logic               Reset,
    output logic [ADDR_W-1:0]  oAddress,
    input  logic [INSTR_W-1:0] iInstruction,
    input  logic               iStall,
    input  logic               iBranchTaken,
    input  logic [ADDR_W-1:0]  iBranchTarget,
    output logic [INSTR_W-1:0] oInstruction,
    output logic [3:0]         oOperation,
    output logic [7:0]         oDestination,
    output logic [7:0]         oSource1,
    output logic [7:0]         oSource0,
    output logic [ADDR_W-1:0]  oPC,
    output logic               oValid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        oFetchCount,
    output logic [31:0]        oStallCount
`endif
);

    logic [ADDR_W-1:0]  pc_s;
    logic               advance_s;
    logic [INSTR_W-1:0] instr_d, instr_q;
    logic [ADDR_W-1:0]  opc_d, opc_q;
    logic               valid_d, valid_q;

    assign advance_s = !iBranchTaken && !iStall;

    program_counter #(
        .ADDR_W     (ADDR_W),
        .RESET_ADDR (RESET_ADDR)
    ) u_pc (
        .clk        (Clock),
        .reset      (Reset),
        .advance_en (advance_s),
        .load_en    (iBranchTaken),
        .load_value (iBranchTarget),
        .pc         (pc_s)
    );

    // A branch squashes the fall-through word; a stall holds the whole register.
    always_comb begin
        instr_d = instr_q;
        opc_d   = opc_q;
        valid_d = valid_q;
        if (iBranchTaken) begin
            instr_d = NOP_WORD;
            opc_d   = pc_s;
            valid_d = 1'b0;
        end else if (!iStall) begin
            instr_d = iInstruction;
            opc_d   = pc_s;
            valid_d = 1'b1;
        end else begin
            instr_d = instr_q;
            opc_d   = opc_q;
            valid_d = valid_q;
        end
    end

    // Instruction register, fetch address and valid flag.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            instr_q <= NOP_WORD;
            opc_q   <= {ADDR_W{1'b0}};
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            opc_q   <= opc_d;
            valid_q <= valid_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_d, fetch_cnt_q;
    logic [31:0] stall_cnt_d, stall_cnt_q;

    // Branch cycles are counted as neither a fetch nor a stall.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (iBranchTaken) begin
            fetch_cnt_d = fetch_cnt_q;
            stall_cnt_d = stall_cnt_q;
        end else if (iStall) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign oFetchCount = fetch_cnt_q;
    assign oStallCount = stall_cnt_q;
`endif

    assign oAddress     = pc_s;
    assign oInstruction = instr_q;
    assign oPC          = opc_q;
    assign oValid       = valid_q;
    assign oOperation   = instr_q[OP_MSB:OP_LSB];
    assign oDestination = instr_q[DST_MSB:DST_LSB];
    assign oSource1     = instr_q[SRC1_MSB:SRC1_LSB];
    assign oSource0     = instr_q[SRC0_MSB:SRC0_LSB];

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the instruction ROM and downstream of the execute logic.
- Owns the program counter and drives the ROM address.
- Registers the ROM's 28-bit instruction word into an instruction register, split into opcode/destination/source fields for the decode/execute stage.
- Supports stall requests from multi-cycle execute operations (e.g. IMUL) and branch redirects.

Parameters:
- ADDR_W, 16, program counter / ROM address width
- INSTR_W, 28, instruction word width (4-bit opcode + 24-bit operand)
- RESET_ADDR, 16'd0, PC value after reset
- NOP_WORD, 28'd0, bubble instruction inserted on reset and branch (opcode field = NOP)

Ports:
- Clock  in  1  single clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- oAddress  out  ADDR_W  ROM address; combinational copy of PC
- iInstruction  in  INSTR_W  ROM data for oAddress (combinational ROM)
- iStall  in  1  hold the fetch stage this cycle
- iBranchTaken  in  1  redirect the PC this cycle
- iBranchTarget  in  ADDR_W  redirect address
- oInstruction  out  INSTR_W  registered instruction word
- oOperation  out  4  oInstruction[27:24]
- oDestination  out  8  oInstruction[23:16]
- oSource1  out  8  oInstruction[15:8]
- oSource0  out  8  oInstruction[7:0]
- oPC  out  ADDR_W  address oInstruction was fetched from
- oValid  out  1  oInstruction is a real fetched instruction, not a bubble

Behaviour:
- Reset (synchronous, any cycle, overrides everything, including mid-stall and mid-branch):
  - PC=RESET_ADDR, oInstruction=NOP_WORD, oPC=0, oValid=0.
  - Field outputs follow oInstruction, so all are 0 with the default NOP_WORD.
- Priority per cycle: Reset > iBranchTaken > iStall > normal advance.
- Normal advance:
  - oInstruction<=iInstruction, oPC<=PC, oValid<=1, PC<=PC+1.
  - Latency: the word at address A appears on oInstruction one edge after PC=A.
  - Sustained throughput is 1 instruction/cycle.
- Stall (iStall=1, no branch): PC, oInstruction, oPC and oValid all hold. No ROM word is dropped; the word at the current PC is re-presented next cycle.
- Branch (iBranchTaken=1):
  - PC<=iBranchTarget, oInstruction<=NOP_WORD, oValid<=0, oPC<=PC.
  - The fall-through word is discarded: exactly one bubble.
  - A branch taken during a stall still redirects; the stall is ignored that cycle.
- Wrap-around: PC=2^ADDR_W-1 advances to 0. No flag is raised.
- Field outputs are pure slices of oInstruction; there is no extra register stage.
- oAddress is combinational from PC, so the ROM sees a new address in the same cycle the PC changes.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds two outputs:
  - oFetchCount [31:0]: increments on each normal advance.
  - oStallCount [31:0]: increments on each cycle with iStall=1 and no branch.
  - Both are cleared by Reset, wrap at 2^32, and do not count branch cycles.
- When undefined, neither port nor counter exists, and behaviour is otherwise identical.

Decomposition:
- Opcode constants (NOP, STO, IMUL, LED, ...) and field bit positions live in the shared definitions include used by ROM/ALU.
- NOP_WORD is built from the NOP constant there.
- One natural sub-module, program_counter:
  - Inputs: Reset, advance enable, load enable, load value.
  - Output: PC.
  - Implements the priority and wrap rules above.
- fetch_unit instantiates program_counter and adds the instruction register, valid flag and optional counters.

Test Plan:
- Reset held 2 cycles, then released with a ROM model (addr N returns {4'hN, 24'dN}) -> oValid=0, oAddress=0 during reset; oInstruction=0x0000000, oPC=0, oValid=1 one edge after release; then oPC=1, oInstruction=0x1000001.
- Run free 5 cycles then iStall=1 for 3 cycles -> oInstruction/oPC frozen at oPC=4 and oAddress held at 5 during the stall; oPC=5 on the first edge after iStall drops.
- iBranchTaken=1, iBranchTarget=16'h0100 while PC=7 -> next edge oValid=0, oInstruction=NOP_WORD, oAddress=0x0100; following edge oPC=0x0100, oValid=1.
- Branch and stall asserted together, target 0x0020 -> branch wins; oAddress=0x0020 next cycle, one bubble.
- Branch to 0xFFFF, run 2 cycles -> oPC=0xFFFF then oPC=0x0000, no glitch on oValid.
- Reset asserted mid-stall at PC=9 (FETCH_PERF_CNT_EN defined, 9 fetches and 3 stalls counted beforehand) -> counters read 9/3 before reset; after reset edge PC=0, oValid=0, both counters 0.
